// File: rtl/pipe_stage_skid.sv
// Pipeline register with a 2-entry skid buffer, registered in_ready and synchronous flush.
// Optional saturating stall/bubble counters are enabled with `define PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [PC_W-1:0]    PC_RESET  = 32'h8000_0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000,
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [1:0]         level
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'b00,
      ST_ONE     = 2'b01,
      ST_ILLEGAL = 2'b10,
      ST_FULL    = 2'b11
   } state_t;

   logic               r_main_valid;
   logic [INSTR_W-1:0] r_main_instr;
   logic [PC_W-1:0]    r_main_pc;
   logic               r_skid_valid;
   logic [INSTR_W-1:0] r_skid_instr;
   logic [PC_W-1:0]    r_skid_pc;
   logic               r_in_ready;
   logic [1:0]         r_level;

   logic   w_push;
   logic   w_pop;
   state_t w_state;

   assign w_push  = in_valid & r_in_ready;
   assign w_pop   = r_main_valid & out_ready;
   assign w_state = state_t'({r_skid_valid, r_main_valid});

   // NOTE: every sequential block uses non-blocking (<=) so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main_instr <= NOP_INSTR;
         r_main_pc    <= PC_RESET;
         r_in_ready   <= 1'b1;
         r_level      <= 2'd0;
      end else if (flush) begin
         // The bubble keeps the PC of the flushing stage so traces stay aligned.
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main_instr <= NOP_INSTR;
         r_main_pc    <= in_pc;
         r_in_ready   <= 1'b1;
         r_level      <= 2'd0;
      end else begin
         case (w_state)
            ST_EMPTY: begin
               if (w_push) begin
                  r_main_valid <= 1'b1;
                  r_main_instr <= in_instr;
                  r_main_pc    <= in_pc;
                  r_level      <= 2'd1;
               end
            end
            ST_ONE: begin
               if (w_pop && w_push) begin
                  r_main_instr <= in_instr;
                  r_main_pc    <= in_pc;
               end else if (w_pop) begin
                  r_main_valid <= 1'b0;
                  r_main_instr <= NOP_INSTR;
                  r_level      <= 2'd0;
               end else if (w_push) begin
                  r_skid_valid <= 1'b1;
                  r_in_ready   <= 1'b0;
                  r_level      <= 2'd2;
               end
            end
            ST_FULL: begin
               if (w_pop) begin
                  r_main_instr <= r_skid_instr;
                  r_main_pc    <= r_skid_pc;
                  r_skid_valid <= 1'b0;
                  r_in_ready   <= 1'b1;
                  r_level      <= 2'd1;
               end
            end
            default: begin
               // Skid without main cannot be reached; fall back to empty if it ever is.
               r_main_valid <= 1'b0;
               r_skid_valid <= 1'b0;
               r_main_instr <= NOP_INSTR;
               r_in_ready   <= 1'b1;
               r_level      <= 2'd0;
            end
         endcase
      end
   end

   // NOTE: skid payload is a data-only register qualified by r_skid_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_skid_instr <= in_instr;
         r_skid_pc    <= in_pc;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_main_valid;
   assign out_instr = r_main_instr;
   assign out_pc    = r_main_pc;
   assign level     = r_level;

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   // Counters saturate and survive flush; only reset clears them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (r_main_valid && !out_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
         if (!r_main_valid && !flush && (r_bubble_cnt != '1))
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
   end

   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized self-checking bench for pipe_stage_skid against a queue-based FIFO model.
// Perf counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;

   localparam logic [31:0] PC_RESET = 32'h8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [1:0]  level;
`ifdef PIPE_STAGE_PERF_EN
   logic [15:0] stall_cnt;
   logic [15:0] bubble_cnt;
   logic        sat_in_ready, sat_out_valid;
   logic [31:0] sat_out_instr, sat_out_pc;
   logic [1:0]  sat_level, sat_stall_cnt, sat_bubble_cnt;
`endif

   always #5 clk = ~clk;

   pipe_stage_skid dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .level(level)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
   );

`ifdef PIPE_STAGE_PERF_EN
   pipe_stage_skid #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(sat_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(sat_out_valid), .out_ready(out_ready), .out_instr(sat_out_instr),
      .out_pc(sat_out_pc), .level(sat_level),
      .stall_cnt(sat_stall_cnt), .bubble_cnt(sat_bubble_cnt)
   );
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   // Reference model: a FIFO of at most two entries plus the PC shown when empty.
   entry_t      m_q[$];
   logic [31:0] m_hold_pc;
   int          m_stall;
   int          m_bubble;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_hold_pc = PC_RESET;
      m_stall   = 0;
      m_bubble  = 0;
   endtask

   // Evaluated at the clock edge using the inputs that were held across it.
   task automatic model_edge();
      bit     push, pop;
      entry_t e;
      if (!reset) begin
         model_reset();
         return;
      end
      if (m_q.size() > 0 && !out_ready) m_stall++;
      if (m_q.size() == 0 && !flush)    m_bubble++;
      if (flush) begin
         m_q.delete();
         m_hold_pc = in_pc;
         return;
      end
      push = in_valid && (m_q.size() < 2);
      pop  = (m_q.size() > 0) && out_ready;
      if (pop)  void'(m_q.pop_front());
      if (push) begin
         e.instr = in_instr;
         e.pc    = in_pc;
         m_q.push_back(e);
      end
      if (m_q.size() > 0) m_hold_pc = m_q[0].pc;
   endtask

   task automatic compare_all();
      int sz;
      sz = m_q.size();
      check("out_valid", out_valid, sz > 0);
      check("out_instr", out_instr, (sz > 0) ? m_q[0].instr : NOP);
      check("out_pc",    out_pc,    (sz > 0) ? m_q[0].pc : m_hold_pc);
      check("in_ready",  in_ready,  sz < 2);
      check("level",     level,     sz);
      check("illegal_state", (level != 2'd0) && !out_valid, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt",      stall_cnt,      sat(m_stall, 65535));
      check("bubble_cnt",     bubble_cnt,     sat(m_bubble, 65535));
      check("sat_stall_cnt",  sat_stall_cnt,  sat(m_stall, 3));
      check("sat_bubble_cnt", sat_bubble_cnt, sat(m_bubble, 3));
`endif
   endtask

   task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc;
      out_ready = ordy;
      flush     = fl;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      int stall0, bubble0;
      model_reset();
      #12;
      compare_all();
      @(negedge clk);
      reset = 1'b1;

      // Streaming: back-to-back pushes with downstream always ready.
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 32'h1111_0001 + i, 32'h8000_0000 + 4 * i, 1'b1, 1'b0);
      check("stream_last_instr", out_instr, 32'h1111_0008);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Backpressure: A then B fill both entries, C is held off.
      cycle(1'b1, 32'hAAAA_0000, 32'h8000_0100, 1'b0, 1'b0);
      cycle(1'b1, 32'hBBBB_0000, 32'h8000_0104, 1'b0, 1'b0);
      check("bp_level_full", level, 2'd2);
      check("bp_ready_low", in_ready, 1'b0);
      cycle(1'b1, 32'hCCCC_0000, 32'h8000_0108, 1'b0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      check("bp_b_after_a", out_instr, 32'hBBBB_0000);
      check("bp_ready_after_a", in_ready, 1'b1);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Flush at level 2 with a push offered in the same cycle.
      cycle(1'b1, 32'hAAAA_0001, 32'h8000_0200, 1'b0, 1'b0);
      cycle(1'b1, 32'hBBBB_0001, 32'h8000_0204, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEAD_0000, 32'h8000_0040, 1'b1, 1'b1);
      check("flush_pc", out_pc, 32'h8000_0040);
      check("flush_level", level, 2'd0);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      check("flush_no_ghost", out_valid, 1'b0);

      // Simultaneous push and pop at level 1.
      cycle(1'b1, 32'h5555_0000, 32'h8000_0300, 1'b0, 1'b0);
      cycle(1'b1, 32'h6666_0000, 32'h8000_0304, 1'b1, 1'b0);
      check("pp_level", level, 2'd1);
      check("pp_instr", out_instr, 32'h6666_0000);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);

      // Asynchronous reset mid-operation at level 2.
      cycle(1'b1, 32'h7777_0000, 32'h8000_0400, 1'b0, 1'b0);
      cycle(1'b1, 32'h7777_0001, 32'h8000_0404, 1'b0, 1'b0);
      in_valid = 1'b0;
      reset = 1'b0;
      #1;
      model_reset();
      check("arst_out_valid", out_valid, 1'b0);
      check("arst_out_pc", out_pc, 32'h8000_0000);
      check("arst_out_instr", out_instr, 32'h0);
      check("arst_in_ready", in_ready, 1'b1);
      check("arst_level", level, 2'd0);
      @(negedge clk);
      reset = 1'b1;

`ifdef PIPE_STAGE_PERF_EN
      // One push, 5 stalled cycles, pop, then 3 empty cycles.
      cycle(1'b1, 32'h9999_0000, 32'h8000_0500, 1'b0, 1'b0);
      stall0 = stall_cnt;
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0);
      check("perf_stall5", stall_cnt - stall0, 5);
      check("perf_sat_stall", sat_stall_cnt, 2'd3);
      cycle(1'b0, '0, '0, 1'b1, 1'b0);
      bubble0 = bubble_cnt;
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
      check("perf_bubble3", bubble_cnt - bubble0, 3);
`else
      stall0  = 0;
      bubble0 = 0;
`endif

      // Randomized traffic with occasional flushes.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 9) < 7, $urandom, $urandom, $urandom_range(0, 9) < 6,
               $urandom_range(0, 99) < 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
